// File: rtl/rz_code_if.sv
// Pixel-word handshake and serial line between the frame sequencer and rz_code.
interface rz_code_if;
  logic [23:0] RGB;
  logic        done_sig;
  logic        symbol;
  logic        RZ_data;

  modport master (
    output RGB,
    output done_sig,
    input  symbol,
    input  RZ_data
  );

  modport slave (
    input  RGB,
    input  done_sig,
    output symbol,
    output RZ_data
  );
endinterface

// File: rtl/rz_code.sv
// WS2812-class return-to-zero encoder: shifts a 24-bit word out MSB-first on RZ_data.
// Optional one-deep word buffer enabled by defining RZ_CODE_WORD_BUFFER_EN.
module rz_code #(
  parameter int unsigned T0H  = 20,
  parameter int unsigned T1H  = 40,
  parameter int unsigned TBIT = 62,
  parameter int unsigned TRST = 2600
) (
  input  logic     clk,
  input  logic     rst_n,
  rz_code_if.slave bus
);

  localparam int unsigned CntMax = (TBIT > TRST) ? TBIT : TRST;
  localparam int unsigned CntW   = ($clog2(CntMax) > 12) ? $clog2(CntMax) : 12;

  localparam logic [CntW-1:0] RstLast = CntW'(TRST - 1);
  localparam logic [CntW-1:0] BitLast = CntW'(TBIT - 1);
  localparam logic [CntW-1:0] T0Last  = CntW'(T0H - 1);
  localparam logic [CntW-1:0] T1Last  = CntW'(T1H - 1);

  localparam logic [1:0] StInit = 2'd0;
  localparam logic [1:0] StIdle = 2'd1;
  localparam logic [1:0] StHigh = 2'd2;
  localparam logic [1:0] StLow  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      bit_q, bit_d;
  logic [23:0]     shreg_q, shreg_d;
  logic            rz_q;
  logic            symbol_q, symbol_d;
  logic            start;
  logic [23:0]     start_word;
  logic            queued;
  logic [23:0]     queued_word;
  logic [CntW-1:0] high_last;

`ifdef RZ_CODE_WORD_BUFFER_EN
  logic [23:0] hold_q, hold_d;
  logic        pend_q, pend_d;

  // A word arriving on the very edge a slot frees up wins over the held one.
  assign queued      = pend_q | bus.done_sig;
  assign queued_word = bus.done_sig ? bus.RGB : hold_q;
`else
  assign queued      = 1'b0;
  assign queued_word = bus.RGB;
`endif

  assign high_last = shreg_q[23] ? T1Last : T0Last;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    symbol_d   = 1'b0;
    start      = 1'b0;
    start_word = queued_word;
`ifdef RZ_CODE_WORD_BUFFER_EN
    hold_d = hold_q;
    pend_d = pend_q;
    if (bus.done_sig && (state_q != StIdle)) begin
      hold_d = bus.RGB;
      pend_d = 1'b1;
    end
`endif

    case (state_q)
      StInit: begin
        if (cnt_q == RstLast) begin
          cnt_d = '0;
          if (queued) start = 1'b1;
          else        state_d = StIdle;
        end
      end
      StIdle: begin
        cnt_d = '0;
        if (bus.done_sig) begin
          start      = 1'b1;
          start_word = bus.RGB;
        end
      end
      StHigh: begin
        if (cnt_q == high_last) state_d = StLow;
      end
      StLow: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (bit_q == 5'd23) begin
            symbol_d = 1'b1;
            if (queued) start = 1'b1;
            else        state_d = StIdle;
          end else begin
            bit_d   = bit_q + 5'd1;
            shreg_d = shreg_q << 1;
            state_d = StHigh;
          end
        end
      end
      default: state_d = StInit;
    endcase

    if (start) begin
      state_d = StHigh;
      cnt_d   = '0;
      bit_d   = '0;
      shreg_d = start_word;
`ifdef RZ_CODE_WORD_BUFFER_EN
      pend_d  = 1'b0;
`endif
    end
  end

  // RZ_data is registered from the next state so it is high exactly while in HIGH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StInit;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      rz_q     <= 1'b0;
      symbol_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      rz_q     <= (state_d == StHigh);
      symbol_q <= symbol_d;
    end
  end

`ifdef RZ_CODE_WORD_BUFFER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      pend_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      pend_q <= pend_d;
    end
  end
`endif

  assign bus.RZ_data = rz_q;
  assign bus.symbol  = symbol_q;

endmodule

// File: tb/tb_rz_code.sv
// Bench for rz_code: table vectors, corner sequences and random traffic vs a waveform model.
module tb_rz_code;

  localparam int T0H  = 20;
  localparam int T1H  = 40;
  localparam int TBIT = 62;
  localparam int TRST = 2600;
  localparam int WORD = 24 * TBIT;

  logic clk = 1'b0;
  logic rst_n;
  rz_code_if bus ();

  rz_code #(
    .T0H (T0H),
    .T1H (T1H),
    .TBIT(TBIT),
    .TRST(TRST)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Model: remaining latch cycles, or position within the word being sent.
  int          m_init_left;
  bit          m_active;
  int          m_pos;
  logic [23:0] m_word;
  bit          m_sym;
  bit          m_pend;
  logic [23:0] m_hold;

  typedef struct {
    logic [23:0] rgb;
    int          exp_highs;
    int          exp_sym_at;
  } vec_t;

  vec_t tbl[5];

  function automatic void check_int(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_init_left = TRST;
    m_active    = 1'b0;
    m_pos       = 0;
    m_sym       = 1'b0;
    m_pend      = 1'b0;
  endfunction

  function automatic void model_start(logic [23:0] w);
    m_active = 1'b1;
    m_pos    = 0;
    m_word   = w;
    m_pend   = 1'b0;
  endfunction

  function automatic int model_rz();
    int b;
    int ph;
    if (!m_active) return 0;
    b  = m_pos / TBIT;
    ph = m_pos % TBIT;
    return (ph < (m_word[23 - b] ? T1H : T0H)) ? 1 : 0;
  endfunction

  task automatic model_step();
    m_sym = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (m_init_left > 0) begin
      m_init_left--;
`ifdef RZ_CODE_WORD_BUFFER_EN
      if (bus.done_sig) begin
        m_hold = bus.RGB;
        m_pend = 1'b1;
      end
      if (m_init_left == 0 && m_pend) model_start(m_hold);
`endif
    end else if (m_active) begin
`ifdef RZ_CODE_WORD_BUFFER_EN
      if (bus.done_sig) begin
        m_hold = bus.RGB;
        m_pend = 1'b1;
      end
`endif
      m_pos++;
      if (m_pos == WORD) begin
        m_sym    = 1'b1;
        m_active = 1'b0;
`ifdef RZ_CODE_WORD_BUFFER_EN
        if (m_pend) model_start(m_hold);
`endif
      end
    end else if (bus.done_sig) begin
      model_start(bus.RGB);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_int("rz_data", int'(bus.RZ_data), model_rz());
    check_int("symbol", int'(bus.symbol), int'(m_sym));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_init_left != 0 || m_active || m_pend) begin
      tick();
      n++;
      if (n > 5000) begin
        check_int("wait_idle_timeout", n, 0);
        break;
      end
    end
  endtask

  initial begin
    int          highs, sym_n, sym_at, run, first_hi, bad_w;
    int          widths[$];
    int          sym_ks[$];
    logic [23:0] rgb;

    tbl[0] = '{24'hFF0000, 640, 1489};
    tbl[1] = '{24'hA5A5A5, 720, 1489};
    tbl[2] = '{24'h000000, 480, 1489};
    tbl[3] = '{24'hFFFFFF, 960, 1489};
    tbl[4] = '{24'h800001, 520, 1489};

    rst_n        = 1'b0;
    bus.done_sig = 1'b0;
    bus.RGB      = '0;
    model_reset();
    m_hold = '0;
    m_word = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // Latch period: a pulse at cycle 100 must not start a word before TRST elapses.
    highs = 0;
    sym_n = 0;
    for (int k = 1; k <= TRST; k++) begin
      tick();
      if (k == 100) begin
        bus.done_sig = 1'b1;
        bus.RGB      = $urandom;
      end
      if (k == 101) bus.done_sig = 1'b0;
      if (bus.RZ_data) highs++;
      if (bus.symbol) sym_n++;
    end
    check_int("init_rz_highs", highs, 0);
    check_int("init_symbols", sym_n, 0);
    wait_idle();

    for (int v = 0; v < 5; v++) begin
      wait_idle();
      rgb          = tbl[v].rgb;
      bus.RGB      = rgb;
      bus.done_sig = 1'b1;
      highs  = 0;
      sym_n  = 0;
      sym_at = 0;
      run    = 0;
      widths.delete();
      for (int k = 1; k <= 1500; k++) begin
        tick();
        if (k == 1) begin
          bus.done_sig = 1'b0;
          bus.RGB      = $urandom;
        end
        if (bus.RZ_data) begin
          highs++;
          run++;
        end else if (run > 0) begin
          widths.push_back(run);
          run = 0;
        end
        if (bus.symbol) begin
          sym_n++;
          if (sym_at == 0) sym_at = k;
        end
      end
      check_int("tbl_highs", highs, tbl[v].exp_highs);
      check_int("tbl_sym_at", sym_at, tbl[v].exp_sym_at);
      check_int("tbl_sym_count", sym_n, 1);
      bad_w = 0;
      for (int b = 0; b < 24; b++) begin
        if (b >= widths.size() || widths[b] != (rgb[23 - b] ? T1H : T0H)) bad_w++;
      end
      check_int("tbl_width_errors", bad_w + (widths.size() != 24 ? 100 : 0), 0);
    end

    // Second word offered during bit 5 of a word in flight.
    wait_idle();
    bus.RGB      = $urandom;
    bus.done_sig = 1'b1;
    sym_ks.delete();
    for (int k = 1; k <= 2 * WORD + 200; k++) begin
      tick();
      if (k == 1) bus.done_sig = 1'b0;
      if (k == 5 * TBIT + 10) begin
        bus.RGB      = 24'h00FFFF;
        bus.done_sig = 1'b1;
      end
      if (k == 5 * TBIT + 11) bus.done_sig = 1'b0;
      if (bus.symbol) sym_ks.push_back(k);
    end
`ifdef RZ_CODE_WORD_BUFFER_EN
    check_int("overlap_sym_count", sym_ks.size(), 2);
    if (sym_ks.size() == 2) check_int("overlap_sym_gap", sym_ks[1] - sym_ks[0], WORD);
`else
    check_int("overlap_sym_count", sym_ks.size(), 1);
`endif
    if (sym_ks.size() > 0) check_int("overlap_first_sym", sym_ks[0], WORD + 1);

    // Asynchronous reset in HIGH of bit 10, then done_sig held across the latch period.
    wait_idle();
    bus.RGB      = $urandom;
    bus.done_sig = 1'b1;
    for (int k = 1; k <= 10 * TBIT + 6; k++) begin
      tick();
      if (k == 1) bus.done_sig = 1'b0;
    end
    check_int("pre_reset_rz", int'(bus.RZ_data), 1);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_int("async_clr_rz", int'(bus.RZ_data), 0);
    check_int("async_clr_symbol", int'(bus.symbol), 0);
    bus.RGB      = $urandom;
    bus.done_sig = 1'b1;
    tick();
    tick();
    tick();
    rst_n    = 1'b1;
    first_hi = 0;
    sym_ks.delete();
    for (int k = 1; k <= TRST + 3200; k++) begin
      tick();
      if (bus.RZ_data && first_hi == 0) first_hi = k;
      if (bus.symbol) sym_ks.push_back(k);
    end
    bus.done_sig = 1'b0;
`ifdef RZ_CODE_WORD_BUFFER_EN
    check_int("post_reset_first_high", first_hi, TRST);
    check_int("held_sym_count", sym_ks.size(), 2);
    if (sym_ks.size() == 2) check_int("held_sym_gap", sym_ks[1] - sym_ks[0], WORD);
`else
    check_int("post_reset_first_high", first_hi, TRST + 1);
    check_int("held_sym_count", sym_ks.size(), 2);
    if (sym_ks.size() == 2) check_int("held_sym_gap", sym_ks[1] - sym_ks[0], WORD + 1);
`endif

    // Random traffic: sparse done_sig pulses with random words, checked every cycle.
    wait_idle();
    for (int k = 0; k < 12 * 1600; k++) begin
      tick();
      bus.done_sig = ($urandom_range(0, 299) == 0);
      bus.RGB      = $urandom;
    end
    bus.done_sig = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
